// File: rtl/eps_reparam_sampler.sv
// rtl/eps_reparam_sampler.sv - reparameterised latent sampler z = mu + sigma*eps with saturation
// Optional build macro: SIGN_FLIP_EN (antithetic sampling, alternate samples use -eps).
module eps_reparam_sampler #(
  parameter int W    = 16,
  parameter int FRAC = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] eps_in,
  input  logic [W-1:0] mu_in,
  input  logic [W-1:0] sigma_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] z_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         sat_flag,
  output logic [15:0]  sample_cnt
);

  // Product of a signed W-bit sigma and a zero-extended W-bit eps needs 2W+1 bits;
  // adding mu needs one more bit so the saturation compare never wraps.
  localparam int PW = 2 * W + 1;
  localparam int SW = 2 * W + 2;

  localparam logic signed [SW-1:0] Z_MAX = {{(W + 3){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [SW-1:0] Z_MIN = {{(W + 3){1'b1}}, {(W - 1){1'b0}}};
  localparam logic [W-1:0] Z_POS_SAT = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0] Z_NEG_SAT = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SAT  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]          mu_q, mu_d;
  logic [W-1:0]          sigma_q, sigma_d;
  logic [W-1:0]          eps_q, eps_d;
  logic signed [PW-1:0]  prod_q, prod_d;
  logic [W-1:0]          z_q, z_d;
  logic                  sat_q, sat_d;
  logic [15:0]           cnt_q, cnt_d;

`ifdef SIGN_FLIP_EN
  logic flip_q, flip_d;
`endif

  logic                  use_neg;
  logic signed [PW-1:0]  sigma_ext;
  logic signed [PW-1:0]  eps_ext;
  logic signed [PW-1:0]  prod_full;
  logic signed [PW-1:0]  prod_signed;
  logic signed [PW-1:0]  prod_shift;
  logic signed [SW-1:0]  sum;

`ifdef SIGN_FLIP_EN
  // flip_q has already toggled by the time the sample is in MUL, so the
  // polarity used is the inverse of its current value: 1st sample +eps, 2nd -eps.
  assign use_neg = ~flip_q;
`else
  assign use_neg = 1'b0;
`endif

  assign sigma_ext   = {{(W + 1){sigma_q[W-1]}}, sigma_q};
  assign eps_ext     = {{(W + 1){1'b0}}, eps_q};
  assign prod_full   = sigma_ext * eps_ext;
  // Negation happens before the shift so that -eps floors toward -inf on the negated product.
  assign prod_signed = use_neg ? -prod_full : prod_full;
  assign prod_shift  = prod_signed >>> FRAC;
  assign sum         = {{(W + 2){mu_q[W-1]}}, mu_q} + {prod_q[PW-1], prod_q};

  assign z_out      = z_q;
  assign sat_flag   = sat_q;
  assign sample_cnt = cnt_q;

  // Next-state, datapath updates and handshake outputs for the four-phase sample sequence.
  always_comb begin
    state_d   = state_q;
    mu_d      = mu_q;
    sigma_d   = sigma_q;
    eps_d     = eps_q;
    prod_d    = prod_q;
    z_d       = z_q;
    sat_d     = sat_q;
    cnt_d     = cnt_q;
`ifdef SIGN_FLIP_EN
    flip_d    = flip_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mu_d    = mu_in;
          sigma_d = sigma_in;
          eps_d   = eps_in;
`ifdef SIGN_FLIP_EN
          flip_d  = ~flip_q;
`endif
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        prod_d  = prod_shift;
        state_d = S_SAT;
      end
      S_SAT: begin
        if (sum > Z_MAX) begin
          z_d   = Z_POS_SAT;
          sat_d = 1'b1;
        end else if (sum < Z_MIN) begin
          z_d   = Z_NEG_SAT;
          sat_d = 1'b1;
        end else begin
          z_d   = sum[W-1:0];
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any sample in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mu_q    <= '0;
      sigma_q <= '0;
      eps_q   <= '0;
      prod_q  <= '0;
      z_q     <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= 16'd0;
`ifdef SIGN_FLIP_EN
      flip_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mu_q    <= mu_d;
      sigma_q <= sigma_d;
      eps_q   <= eps_d;
      prod_q  <= prod_d;
      z_q     <= z_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
`ifdef SIGN_FLIP_EN
      flip_q  <= flip_d;
`endif
    end
  end

endmodule

// File: tb/tb_eps_reparam_sampler.sv
// tb/tb_eps_reparam_sampler.sv - self-checking bench for eps_reparam_sampler
module tb_eps_reparam_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] eps_in, mu_in, sigma_in;
  logic        in_valid, in_ready;
  logic [15:0] z_out;
  logic        out_valid, out_ready;
  logic        sat_flag;
  logic [15:0] sample_cnt;

  int total = 0;
  int bad   = 0;

`ifdef SIGN_FLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  eps_reparam_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .eps_in     (eps_in),
    .mu_in      (mu_in),
    .sigma_in   (sigma_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .z_out      (z_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sat_flag   (sat_flag),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: z = mu + floor(+/-sigma*eps / 2^10), clamped to signed 16 bits; bit 16 = saturated.
  function automatic logic [16:0] zmodel(input logic [15:0] mu, input logic [15:0] sg,
                                         input logic [15:0] ep, input bit neg);
    longint sv, ev, mv, p, q, s;
    logic [63:0] su;
    sv = longint'($signed(sg));
    ev = longint'(ep);
    mv = longint'($signed(mu));
    p  = sv * ev;
    if (neg) p = -p;
    q = p / 1024;
    if (p < 0 && (p % 1024) != 0) q = q - 1;
    s = mv + q;
    if (s > 32767)  return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    su = s;
    return {1'b0, su[15:0]};
  endfunction

  // Model state: a pending sample with its accept time; result visible from accept+2.
  bit          m_started = 1'b0;
  bit          m_pending = 1'b0;
  bit          m_ov      = 1'b0;
  bit          m_sat     = 1'b0;
  bit          m_flip    = 1'b0;
  logic [15:0] m_z       = 16'h0;
  logic [15:0] m_cnt     = 16'h0;
  logic [16:0] m_res     = 17'h0;
  int          ecount    = 0;
  int          acc       = 0;

  // Advance the model on each rising edge from the inputs the DUT sees.
  always @(posedge clk) begin
    if (rst) begin
      m_started = 1'b1;
      m_pending = 1'b0;
      m_ov      = 1'b0;
      m_sat     = 1'b0;
      m_flip    = 1'b0;
      m_z       = 16'h0;
      m_cnt     = 16'h0;
    end else if (m_started) begin
      if (!m_pending) begin
        if (in_valid) begin
          m_res     = zmodel(mu_in, sigma_in, eps_in, FLIP && m_flip);
          m_flip    = !m_flip;
          m_pending = 1'b1;
          acc       = ecount;
        end
      end else if (m_ov) begin
        if (out_ready) begin
          m_ov      = 1'b0;
          m_pending = 1'b0;
          m_cnt     = m_cnt + 16'd1;
        end
      end else if (ecount == acc + 2) begin
        m_z   = m_res[15:0];
        m_sat = m_sat | m_res[16];
        m_ov  = 1'b1;
      end
    end
    ecount++;
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready",   {31'd0, in_ready},  {31'd0, !m_pending});
      chk("out_valid",  {31'd0, out_valid}, {31'd0, m_ov});
      chk("z_out",      {16'd0, z_out},     {16'd0, m_z});
      chk("sat_flag",   {31'd0, sat_flag},  {31'd0, m_sat});
      chk("sample_cnt", {16'd0, sample_cnt}, {16'd0, m_cnt});
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present a sample, wait (bounded) for in_ready, return at the negedge after the accept edge.
  task automatic send(input logic [15:0] mu, input logic [15:0] sg, input logic [15:0] ep);
    int n;
    n = 0;
    mu_in    = mu;
    sigma_in = sg;
    eps_in   = ep;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    eps_in   = ep ^ 16'hA5A5;
    mu_in    = 16'h5A5A;
    sigma_in = 16'h3C3C;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [15:0] mu;
    logic [15:0] sg;
    logic [15:0] ep;
  } vec_t;

  vec_t vecs[6] = '{
    '{16'h0000, 16'hFFFF, 16'h0001},
    '{16'h1234, 16'h0001, 16'hFFFF},
    '{16'h0000, 16'h0000, 16'hABCD},
    '{16'h8000, 16'h7FFF, 16'hFFFF},
    '{16'h7FFF, 16'h8000, 16'hFFFF},
    '{16'hF000, 16'h0400, 16'h0000}
  };

  initial begin
    int lat;
    logic [15:0] z1, z2;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mu_in     = 16'h0;
    sigma_in  = 16'h0;
    eps_in    = 16'h0;

    do_reset();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_z_out",     {16'd0, z_out},     32'd0);
    chk("rst_sat",       {31'd0, sat_flag},  32'd0);
    chk("rst_cnt",       {16'd0, sample_cnt}, 32'd0);

    chk("model_basic",     {15'd0, zmodel(16'h0400, 16'h0200, 16'h0400, 1'b0)}, {15'd0, 17'h00600});
    chk("model_floor_neg", {15'd0, zmodel(16'h0000, 16'hFFFF, 16'h0001, 1'b0)}, {15'd0, 17'h0FFFF});
    chk("model_neg_first", {15'd0, zmodel(16'h0000, 16'hFFFF, 16'h0001, 1'b1)}, {15'd0, 17'h00000});

    // Basic sample and latency
    send(16'h0400, 16'h0200, 16'h0400);
    wait_out(lat);
    chk("t1_latency", lat, 32'd2);
    chk("t1_z",   {16'd0, z_out}, 32'h0600);
    chk("t1_sat", {31'd0, sat_flag}, 32'd0);
    @(negedge clk);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t1_cnt", {16'd0, sample_cnt}, 32'd1);

    // Positive saturation, sticky flag through a clean sample
    do_reset();
    send(16'h7000, 16'h7FFF, 16'h0400);
    wait_out(lat);
    chk("t2_z",   {16'd0, z_out}, 32'h7FFF);
    chk("t2_sat", {31'd0, sat_flag}, 32'd1);
    @(negedge clk);
    send(16'h0123, 16'h0000, 16'h1234);
    wait_out(lat);
    chk("t2_clean_z",   {16'd0, z_out}, 32'h0123);
    chk("t2_clean_sat", {31'd0, sat_flag}, 32'd1);

    // Negative saturation
    do_reset();
    send(16'h8800, 16'h8000, 16'h0400);
    wait_out(lat);
    chk("t3_z",   {16'd0, z_out}, 32'h8000);
    chk("t3_sat", {31'd0, sat_flag}, 32'd1);

    // Backpressure with ignored input pulses
    do_reset();
    out_ready = 1'b0;
    send(16'h0100, 16'h0400, 16'h0800);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_hold_z", {16'd0, z_out}, 32'h0900);
      chk("t4_hold_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = i[0];
      mu_in    = 16'h1111;
      sigma_in = 16'h2222;
      eps_in   = 16'(i);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t4_release_cnt", {16'd0, sample_cnt}, 32'd1);
    chk("t4_z_held", {16'd0, z_out}, 32'h0900);

    // Reset while the sample is in MUL
    do_reset();
    send(16'h0400, 16'h0400, 16'h0400);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_cnt", {16'd0, sample_cnt}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_output", {31'd0, out_valid}, 32'd0);
    end
    chk("t5_z", {16'd0, z_out}, 32'd0);

    // Antithetic pair (or identical pair in the default build)
    do_reset();
    send(16'h0000, 16'h0400, 16'h0100);
    wait_out(lat);
    z1 = z_out;
    @(negedge clk);
    send(16'h0000, 16'h0400, 16'h0100);
    wait_out(lat);
    z2 = z_out;
    chk("t6_first", {16'd0, z1}, 32'h0100);
    chk("t6_second", {16'd0, z2}, FLIP ? 32'hFF00 : 32'h0100);

    // Boundary vectors checked by the model, with idle gaps between samples
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].mu, vecs[i].sg, vecs[i].ep);
      wait_out(lat);
      if (i == 0) chk("t7_floor_neg", {16'd0, z_out}, 32'hFFFF);
      repeat (i % 3 + 1) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("t7_cnt", {16'd0, sample_cnt}, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
